xlr8_sim_mbox_tx: RTL and testbench

Simulation mailbox that carries bytes from the testbench to software running on the AVR core: the bench pushes bytes into an internal FIFO, and software polls a status register and reads a data register in I/O space, each data read popping one byte. It is the bench-to-core counterpart of the simulation support path, which carries core-to-bench results through the GPIO registers. It is instantiated alongside the GPIO block inside the top-level simulation build and is never synthesized into the factory image.

---
 rtl/xlr8_sim_mbox_pkg.sv | 24 ++
 rtl/xlr8_sim_mbox_fifo.sv | 53 +++++
 rtl/xlr8_sim_mbox_tx.sv | 93 +++++++++
 tb/tb_xlr8_sim_mbox_tx.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/xlr8_sim_mbox_pkg.sv
// xlr8_sim_mbox_pkg: status bit positions, default addresses and status packing for the sim mailbox
package xlr8_sim_mbox_pkg;

    localparam int STAT_DAV   = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EOS   = 2;
    localparam int STAT_FLUSH = 6;
    localparam int STAT_IE    = 7;

    localparam logic [5:0] DEF_DATA_ADDR = 6'h1C;
    localparam logic [5:0] DEF_STAT_ADDR = 6'h1D;

    function automatic logic [7:0] pack_stat(input logic dav, input logic full,
                                             input logic eos, input logic ie);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_DAV]  = dav;
        s[STAT_FULL] = full;
        s[STAT_EOS]  = eos;
        s[STAT_IE]   = ie;
        return s;
    endfunction

endpackage

// File: rtl/xlr8_sim_mbox_fifo.sv
// xlr8_sim_mbox_fifo: byte FIFO with push/pop/flush; flush outranks a same-cycle push or pop
module xlr8_sim_mbox_fifo
    import xlr8_sim_mbox_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [7:0]                 push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [7:0]                 head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push = push_i && !flush_i && (count_q != FULL_CNT);
        do_pop  = pop_i && !flush_i && (count_q != '0);
        wr_d    = wr_q + PTR_W'(do_push);
        rd_d    = flush_i ? wr_q : rd_q + PTR_W'(do_pop);
        count_d = flush_i ? '0 : count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/xlr8_sim_mbox_tx.sv
// xlr8_sim_mbox_tx: bench-to-core mailbox in AVR I/O space (DATA pops, STAT status/flush/IE).
// Optional interrupt enabled by defining XLR8_SIM_MBOX_IRQ_EN.
module xlr8_sim_mbox_tx
    import xlr8_sim_mbox_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter logic [5:0] DATA_ADDR = DEF_DATA_ADDR,
    parameter logic [5:0] STAT_ADDR = DEF_STAT_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] adr,
    input  logic       iore,
    input  logic       iowe,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    output logic       io_out_en,
    input  logic       push_valid,
    input  logic [7:0] push_data,
    output logic       push_ready,
    input  logic       eos,
    output logic       mbox_irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0] count;
    logic [7:0]     head, stat;
    logic           dav, full, data_sel, stat_sel, stat_wr, flush, pop, push, ie;
    logic           eos_flag_q, eos_flag_d;
    logic           unused;

    always_comb begin
        dav        = count != '0;
        full       = count == FULL_CNT;
        data_sel   = adr == DATA_ADDR;
        stat_sel   = adr == STAT_ADDR;
        stat_wr    = iowe && stat_sel;
        flush      = stat_wr && dbus_in[STAT_FLUSH];
        pop        = iore && data_sel && dav;
        push_ready = !full;
        push       = push_valid && push_ready;
        eos_flag_d = flush ? 1'b0 : (eos_flag_q || eos);
        stat       = pack_stat(dav, full, eos_flag_q && !dav, ie);
        io_out_en  = iore && (data_sel || stat_sel);
        dbus_out   = !io_out_en ? 8'h00 : data_sel ? (dav ? head : 8'h00) : stat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) eos_flag_q <= 1'b0;
        else     eos_flag_q <= eos_flag_d;
    end

`ifdef XLR8_SIM_MBOX_IRQ_EN
    logic ie_q, ie_d, irq_q, irq_d;

    always_comb begin
        ie_d  = stat_wr ? dbus_in[STAT_IE] : ie_q;
        irq_d = ie_q && dav;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    assign ie       = ie_q;
    assign mbox_irq = irq_q;
    assign unused   = ^dbus_in[5:0];
`else
    assign ie       = 1'b0;
    assign mbox_irq = 1'b0;
    assign unused   = ^{dbus_in[7], dbus_in[5:0]};
`endif

    xlr8_sim_mbox_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .count_o     (count)
    );

endmodule

// File: tb/tb_xlr8_sim_mbox_tx.sv
// tb_xlr8_sim_mbox_tx: directed test-plan sequences plus random traffic against a queue-based mailbox model
module tb_xlr8_sim_mbox_tx;

    localparam int DEPTH = 16;
    localparam logic [5:0] DA = 6'h1C;
    localparam logic [5:0] SA = 6'h1D;

    logic       clk = 1'b0, rst = 1'b1;
    logic [5:0] adr = '0;
    logic       iore = 1'b0, iowe = 1'b0, push_valid = 1'b0, eos = 1'b0;
    logic [7:0] dbus_in = '0, push_data = '0;
    logic [7:0] dbus_out;
    logic       io_out_en, push_ready, mbox_irq;

    xlr8_sim_mbox_tx dut (
        .clk(clk), .rst(rst), .adr(adr), .iore(iore), .iowe(iowe), .dbus_in(dbus_in),
        .dbus_out(dbus_out), .io_out_en(io_out_en), .push_valid(push_valid),
        .push_data(push_data), .push_ready(push_ready), .eos(eos), .mbox_irq(mbox_irq)
    );

    always #5 clk = ~clk;

    int         n_vec = 0, n_err = 0;
    logic [7:0] q[$];
    bit         m_eos = 0, m_ie = 0, m_irq = 0;
    logic [7:0] obs;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_stat();
        return {m_ie, 4'b0, m_eos && q.size() == 0, q.size() == DEPTH, q.size() != 0};
    endfunction

    // One clock cycle: drive at negedge, check combinational outputs, then advance the model at posedge.
    task automatic step(input logic r, input logic w, input logic [5:0] a, input logic [7:0] d,
                        input logic pv, input logic [7:0] pd, input logic e);
        logic       en_exp;
        logic [7:0] do_exp;
        bit         fl, pp, pu;
        @(negedge clk);
        iore = r; iowe = w; adr = a; dbus_in = d; push_valid = pv; push_data = pd; eos = e;
        #1;
        en_exp = r && (a == DA || a == SA);
        do_exp = !en_exp ? 8'h00 : (a == DA) ? (q.size() != 0 ? q[0] : 8'h00) : m_stat();
        chk("io_out_en", {7'b0, io_out_en}, {7'b0, en_exp});
        chk("dbus_out", dbus_out, do_exp);
        chk("push_ready", {7'b0, push_ready}, {7'b0, q.size() != DEPTH});
        chk("mbox_irq", {7'b0, mbox_irq}, {7'b0, m_irq});
        obs = dbus_out;
        @(posedge clk);
        fl = w && a == SA && d[6];
        pp = r && a == DA && q.size() != 0;
        pu = pv && q.size() != DEPTH && !fl;
`ifdef XLR8_SIM_MBOX_IRQ_EN
        m_irq = m_ie && q.size() != 0;
        if (w && a == SA) m_ie = d[7];
`endif
        if (fl) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (pu) q.push_back(pd);
        end
        m_eos = fl ? 1'b0 : (e ? 1'b1 : m_eos);
    endtask

    task automatic rd_stat(); step(1, 0, SA, 0, 0, 0, 0); endtask
    task automatic rd_data(); step(1, 0, DA, 0, 0, 0, 0); endtask
    task automatic wr_stat(input logic [7:0] d); step(0, 1, SA, d, 0, 0, 0); endtask
    task automatic push(input logic [7:0] b); step(0, 0, 0, 0, 1, b, 0); endtask
    task automatic idle(); step(0, 0, 0, 0, 0, 0, 0); endtask

    task automatic mid_reset();
        @(negedge clk);
        iore = 1; adr = SA; iowe = 0; push_valid = 0; eos = 0; rst = 1;
        #1;
        chk("rst_dbus", dbus_out, 8'h00);
        chk("rst_ready", {7'b0, push_ready}, 8'h01);
        chk("rst_irq", {7'b0, mbox_irq}, 8'h00);
        q.delete(); m_eos = 0; m_ie = 0; m_irq = 0;
        @(negedge clk);
        iore = 0; rst = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("por_dbus", dbus_out, 8'h00);
        chk("por_en", {7'b0, io_out_en}, 8'h00);
        chk("por_ready", {7'b0, push_ready}, 8'h01);
        chk("por_irq", {7'b0, mbox_irq}, 8'h00);
        rst = 0;

        rd_stat(); chk("empty_stat", obs, 8'h00);
        rd_data(); chk("empty_data", obs, 8'h00);
        rd_stat(); chk("empty_stat2", obs, 8'h00);

        push(8'hA5); push(8'h3C);
        rd_stat(); chk("two_stat", obs, 8'h01);
        rd_data(); chk("two_rd0", obs, 8'hA5);
        rd_data(); chk("two_rd1", obs, 8'h3C);
        rd_stat(); chk("two_stat_after", obs, 8'h00);

        for (int i = 0; i < 16; i++) push(8'(i));
        rd_stat(); chk("full_stat", obs, 8'h03);
        push(8'hEE);
        for (int i = 0; i < 16; i++) begin
            rd_data(); chk("fill_rd", obs, 8'(i));
        end
        push(8'h77);
        rd_data(); chk("wrap_rd", obs, 8'h77);

        for (int i = 0; i < 16; i++) push(8'(i));
        step(1, 0, DA, 0, 1, 8'h99, 0); chk("full_popush", obs, 8'h00);
        rd_stat(); chk("after_full_pop", obs, 8'h01);
        for (int i = 0; i < 10; i++) rd_data();
        step(1, 0, DA, 0, 1, 8'h55, 0); chk("pp_rd", obs, 8'h0B);
        for (int i = 0; i < 5; i++) rd_data();
        chk("pp_last", obs, 8'h55);
        rd_stat(); chk("pp_stat", obs, 8'h00);

        push(8'h21); push(8'h22);
        step(0, 0, 0, 0, 0, 0, 1);
        rd_stat(); chk("eos_q2", obs, 8'h01);
        rd_data(); rd_stat(); chk("eos_q1", obs, 8'h01);
        rd_data(); rd_stat(); chk("eos_set", obs, 8'h04);
        wr_stat(8'h40);
        rd_stat(); chk("flush_stat", obs, 8'h00);

        wr_stat(8'h80);
        rd_stat();
`ifdef XLR8_SIM_MBOX_IRQ_EN
        chk("ie_stat", obs, 8'h80);
`else
        chk("ie_stat", obs, 8'h00);
`endif
        push(8'h11); idle(); idle();
        rd_data(); chk("irq_rd", obs, 8'h11);
        idle(); idle();
        push(8'h01); push(8'h02); push(8'h03); idle();
        mid_reset();
        rd_stat(); chk("rst_stat", obs, 8'h00);
        rd_data(); chk("rst_data", obs, 8'h00);

        for (int blk = 0; blk < 16; blk++) begin
            int rd_pct;
            rd_pct = (blk % 3 == 0) ? 10 : (blk % 3 == 1) ? 70 : 40;
            for (int i = 0; i < 200; i++) begin
                logic [5:0] a;
                logic [7:0] d;
                int sel;
                sel = $urandom_range(0, 3);
                a = (sel < 2) ? DA : (sel == 2) ? SA : 6'($urandom);
                d = 8'($urandom);
                if ($urandom_range(0, 3) != 0) d[6] = 1'b0;
                step($urandom_range(0, 99) < rd_pct, $urandom_range(0, 19) == 0, a, d,
                     $urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 49) == 0);
            end
            if (blk == 8) mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
